// File: rtl/hbridge_pkg.sv
// Shared encodings for the H-bridge FET sequencer.
// State codes, FET bit positions, drive patterns and defaults.
package hbridge_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int FET_Q1 = 0;
  localparam int FET_Q2 = 1;
  localparam int FET_Q3 = 2;
  localparam int FET_Q4 = 3;

  localparam logic [3:0] PAT_OFF    = 4'b0000;
  localparam logic [3:0] PAT_PRECHG = 4'b1010;
  localparam logic [3:0] PAT_A      = 4'b1001;
  localparam logic [3:0] PAT_B      = 4'b0110;

  localparam int PERIOD_15K = 400;
  localparam int DT_DEFAULT = 4;

endpackage

// File: rtl/hbridge_sequencer_sync_ff.sv
// Multi-flop level synchronizer for asynchronous inputs
// (fault_i, fan_tach_i).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hbridge_sequencer.sv
// H-bridge FET sequencer: precharge, dead-time, orderly stop,
// latched fault shutdown.
module hbridge_sequencer
  import hbridge_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] p_period,
  input  logic [CNT_W-1:0] p_deadtime,
  input  logic [CNT_W-1:0] p_precharge,
  input  logic             fault_i,
  input  logic             fault_clear_i,
  output logic [3:0]       fets_o,
  output logic [2:0]       state_o,
  output logic             fault_o,
  output logic [15:0]      half_cycles_o
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] dt_q, dt_d;
  logic             phase_q, phase_d;
  logic [15:0]      hc_q, hc_d;
  logic             fault_q, fault_d;
  logic [3:0]       fets_q, fets_d;

  logic             fault_s;
  logic [CNT_W-1:0] dt_in;
  logic             last;
  logic             drive;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_fault_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (fault_i),
    .q_o     (fault_s)
  );

  assign dt_in = (p_deadtime == '0) ? CNT_W'(1) : p_deadtime;
  // A zero count is treated as expired so it is reloaded, never wrapped.
  assign last  = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    dt_d    = dt_q;
    phase_d = phase_q;
    hc_d    = hc_q;
    fault_d = fault_q;
    if (fault_s) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable_i && !fault_q) begin
            hc_d    = '0;
            per_d   = p_period;
            dt_d    = dt_in;
            phase_d = 1'b0;
            if (p_precharge != '0) begin
              state_d = ST_PRE;
              cnt_d   = p_precharge;
            end else begin
              state_d = ST_RUN;
              cnt_d   = p_period;
            end
          end
        end
        ST_PRE: begin
          if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (last) begin
            state_d = ST_RUN;
            phase_d = 1'b0;
            cnt_d   = p_period;
            per_d   = p_period;
            dt_d    = dt_in;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (last) begin
            hc_d = hc_q + 16'd1;
            if (!enable_i) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              phase_d = ~phase_q;
              cnt_d   = p_period;
              per_d   = p_period;
              dt_d    = dt_in;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!enable_i) begin
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FAULT: begin
          if (fault_clear_i && !enable_i) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Drive only after dt clocks of the half-cycle; cnt counts per..1.
  assign drive = (per_d > dt_d) && ((per_d - cnt_d) >= dt_d);

  always_comb begin
    fets_d = PAT_OFF;
    unique case (state_d)
      ST_PRE: fets_d = PAT_PRECHG;
      ST_RUN,
      ST_STOP: begin
        if (drive) begin
          fets_d = phase_d ? PAT_B : PAT_A;
        end
      end
      default: fets_d = PAT_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      dt_q    <= '0;
      phase_q <= 1'b0;
      hc_q    <= '0;
      fault_q <= 1'b0;
      fets_q  <= PAT_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      dt_q    <= dt_d;
      phase_q <= phase_d;
      hc_q    <= hc_d;
      fault_q <= fault_d;
      fets_q  <= fets_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      a_no_shoot: assert (!(fets_d[FET_Q1] && fets_d[FET_Q2]) &&
                          !(fets_d[FET_Q3] && fets_d[FET_Q4]));
      a_dead: assert (fets_q == PAT_OFF || fets_d == PAT_OFF ||
                      fets_d == fets_q);
    end
  end

  assign fets_o        = fets_q;
  assign state_o       = state_q;
  assign fault_o       = fault_q;
  assign half_cycles_o = hc_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Directed bench for hbridge_sequencer: run-length segment table
// plus hand-written reset and fault sequences.
module tb_hbridge_sequencer;
  import hbridge_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable_i;
  logic [CNT_W-1:0] p_period;
  logic [CNT_W-1:0] p_deadtime;
  logic [CNT_W-1:0] p_precharge;
  logic             fault_i;
  logic             fault_clear_i;
  logic [3:0]       fets_o;
  logic [2:0]       state_o;
  logic             fault_o;
  logic [15:0]      half_cycles_o;

  always #5 clk = ~clk;

  hbridge_sequencer #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .p_period      (p_period),
    .p_deadtime    (p_deadtime),
    .p_precharge   (p_precharge),
    .fault_i       (fault_i),
    .fault_clear_i (fault_clear_i),
    .fets_o        (fets_o),
    .state_o       (state_o),
    .fault_o       (fault_o),
    .half_cycles_o (half_cycles_o)
  );

  typedef struct {
    logic       en;
    int         per;
    int         dt;
    int         pre;
    int         len;
    logic [3:0] fets;
    logic [2:0] st;
    int         hc;
  } seg_t;

  seg_t       tbl[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] prev_fets = 4'b0000;

  function automatic seg_t mk(logic en, int per, int dt, int pre, int len,
                              logic [3:0] fets, logic [2:0] st, int hc);
    seg_t s;
    s.en = en; s.per = per; s.dt = dt; s.pre = pre;
    s.len = len; s.fets = fets; s.st = st; s.hc = hc;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n) begin
      if ((fets_o[0] && fets_o[1]) || (fets_o[2] && fets_o[3])) begin
        n_err++;
        $display("FAIL shoot_through fets=%b at %0t", fets_o, $time);
      end
      if (prev_fets != 4'b0000 && fets_o != 4'b0000 && fets_o != prev_fets) begin
        n_err++;
        $display("FAIL dead_time fets %b -> %b at %0t", prev_fets, fets_o, $time);
      end
      prev_fets = fets_o;
    end
  endtask

  task automatic run_seg(input int idx, input seg_t s);
    bit         bad;
    int         at;
    logic [3:0] got_f;
    logic [2:0] got_s;
    enable_i    = s.en;
    p_period    = CNT_W'(s.per);
    p_deadtime  = CNT_W'(s.dt);
    p_precharge = CNT_W'(s.pre);
    bad = 0; at = 0; got_f = '0; got_s = '0;
    for (int i = 0; i < s.len; i++) begin
      tick();
      if (!bad && (fets_o !== s.fets || state_o !== s.st)) begin
        bad = 1; at = i; got_f = fets_o; got_s = state_o;
      end
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL seg%0d clk %0d: fets=%b state=%0d, want fets=%b state=%0d",
               idx, at, got_f, got_s, s.fets, s.st);
    end
    if (s.hc >= 0) begin
      n_vec++;
      if (half_cycles_o !== 16'(s.hc)) begin
        n_err++;
        $display("FAIL seg%0d half_cycles=%0d, want %0d", idx, half_cycles_o, s.hc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  initial begin
    bit found;
    reset_n       = 1'b0;
    enable_i      = 1'b1;
    p_period      = 16'd400;
    p_deadtime    = 16'd4;
    p_precharge   = 16'd100;
    fault_i       = 1'b0;
    fault_clear_i = 1'b0;

    // Main sequence: precharge abort, full periods, stop, period change,
    // degenerate configs, then a restart for the fault sequence.
    tbl.push_back(mk(1, 400, 4, 100, 10,  PAT_PRECHG, ST_PRE,  0));
    tbl.push_back(mk(0, 400, 4, 100, 3,   PAT_OFF,    ST_IDLE, 0));
    tbl.push_back(mk(1, 400, 4, 100, 100, PAT_PRECHG, ST_PRE,  0));
    tbl.push_back(mk(1, 400, 4, 100, 4,   PAT_OFF,    ST_RUN,  0));
    tbl.push_back(mk(1, 400, 4, 100, 396, PAT_A,      ST_RUN,  0));
    tbl.push_back(mk(1, 400, 4, 100, 4,   PAT_OFF,    ST_RUN,  1));
    tbl.push_back(mk(1, 400, 4, 100, 396, PAT_B,      ST_RUN,  1));
    tbl.push_back(mk(1, 400, 4, 100, 4,   PAT_OFF,    ST_RUN,  2));
    tbl.push_back(mk(1, 400, 4, 100, 146, PAT_A,      ST_RUN,  2));
    tbl.push_back(mk(0, 400, 4, 100, 250, PAT_A,      ST_STOP, 2));
    tbl.push_back(mk(0, 400, 4, 100, 5,   PAT_OFF,    ST_IDLE, 2));
    tbl.push_back(mk(1, 400, 4, 0,   4,   PAT_OFF,    ST_RUN,  0));
    tbl.push_back(mk(1, 400, 4, 0,   100, PAT_A,      ST_RUN,  0));
    tbl.push_back(mk(1, 200, 4, 0,   296, PAT_A,      ST_RUN,  0));
    tbl.push_back(mk(1, 200, 4, 0,   4,   PAT_OFF,    ST_RUN,  1));
    tbl.push_back(mk(1, 200, 4, 0,   196, PAT_B,      ST_RUN,  1));
    tbl.push_back(mk(1, 200, 4, 0,   4,   PAT_OFF,    ST_RUN,  2));
    tbl.push_back(mk(1, 200, 4, 0,   196, PAT_A,      ST_RUN,  2));
    tbl.push_back(mk(1, 3,   0, 0,   1,   PAT_OFF,    ST_RUN,  3));
    tbl.push_back(mk(1, 3,   0, 0,   2,   PAT_B,      ST_RUN,  3));
    tbl.push_back(mk(1, 3,   0, 0,   1,   PAT_OFF,    ST_RUN,  4));
    tbl.push_back(mk(1, 3,   0, 0,   2,   PAT_A,      ST_RUN,  4));
    tbl.push_back(mk(1, 3,   0, 0,   1,   PAT_OFF,    ST_RUN,  5));
    tbl.push_back(mk(1, 1,   0, 0,   2,   PAT_B,      ST_RUN,  5));
    tbl.push_back(mk(1, 1,   0, 0,   10,  PAT_OFF,    ST_RUN,  15));
    tbl.push_back(mk(0, 1,   0, 0,   3,   PAT_OFF,    ST_IDLE, -1));
    tbl.push_back(mk(1, 400, 4, 0,   4,   PAT_OFF,    ST_RUN,  0));
    tbl.push_back(mk(1, 400, 4, 0,   396, PAT_A,      ST_RUN,  0));
    tbl.push_back(mk(1, 400, 4, 0,   4,   PAT_OFF,    ST_RUN,  1));
    tbl.push_back(mk(1, 400, 4, 0,   100, PAT_B,      ST_RUN,  1));

    // Reset overrides an active run request.
    tick(); tick(); tick();
    chk("reset_fets",  {4'b0, fets_o}, 8'h00);
    chk("reset_state", {5'b0, state_o}, 8'h00);
    chk("reset_fault", {7'b0, fault_o}, 8'h00);
    chk("reset_hc",    half_cycles_o[7:0], 8'h00);
    reset_n = 1'b1;

    foreach (tbl[i]) run_seg(i, tbl[i]);

    // Fault mid phase B: off within 3 clocks of the fault_i edge.
    fault_i = 1'b1;
    found = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fets_o == PAT_OFF && state_o == ST_FAULT) found = 1;
    end
    chk("fault_latency", {7'b0, found}, 8'h01);
    chk("fault_flag",  {7'b0, fault_o}, 8'h01);
    chk("fault_hc",    half_cycles_o[7:0], 8'h01);

    // Clear ignored while the synchronized fault is still high.
    enable_i = 1'b0;
    fault_clear_i = 1'b1;
    tick();
    fault_clear_i = 1'b0;
    chk("clr_while_fault", {5'b0, state_o}, {5'b0, ST_FAULT});

    // Clear ignored while enable_i is high.
    fault_i = 1'b0;
    enable_i = 1'b1;
    tick(); tick(); tick();
    fault_clear_i = 1'b1;
    tick();
    fault_clear_i = 1'b0;
    chk("clr_while_en_state", {5'b0, state_o}, {5'b0, ST_FAULT});
    chk("clr_while_en_flag",  {7'b0, fault_o}, 8'h01);
    chk("fault_fets_hold",    {4'b0, fets_o}, 8'h00);

    // Valid clear.
    enable_i = 1'b0;
    tick();
    fault_clear_i = 1'b1;
    tick();
    fault_clear_i = 1'b0;
    chk("clr_state", {5'b0, state_o}, {5'b0, ST_IDLE});
    chk("clr_flag",  {7'b0, fault_o}, 8'h00);
    chk("clr_fets",  {4'b0, fets_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
